// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
// Parametrised VGA raster timing generator. Two free-running counters
// (h_cnt, v_cnt) walk the raster; every output is a registered decode of the
// counter value present before the enabled edge, so outputs trail the
// counters by exactly one enabled tick.
//
// Ports:
//   clk_vga       in   system clock
//   rst_vga       in   asynchronous, active-high reset
//   pix_en_vga    in   pixel strobe; nothing advances while low
//   h_out_vga     out  horizontal sync (active level H_POL)
//   v_out_vga     out  vertical sync (active level V_POL)
//   video_on      out  high in the visible region
//   horizontal_x  out  pixel column, 0 outside the visible region
//   vertical_y    out  pixel row, 0 outside the visible region
//   line_start    out  pulse at x=0 of every line
//   frame_start   out  pulse at (0,0)
//   rgb_vga       out  colour-bar test pattern (only with VGA_TEST_PATTERN_EN)
//
// Build option: define VGA_TEST_PATTERN_EN to add the 8-bar colour pattern
// output rgb_vga. Without it the port and the pattern logic are absent.

module vga_timing_gen #(
    parameter int H_VIZ   = 640,
    parameter int H_FP    = 16,
    parameter int H_PULSE = 96,
    parameter int H_BP    = 48,
    parameter int V_VIZ   = 480,
    parameter int V_FP    = 10,
    parameter int V_PULSE = 2,
    parameter int V_BP    = 33,
    parameter int H_POL   = 0,
    parameter int V_POL   = 0,
    parameter int CNT_W   = 11
) (
    input  logic             clk_vga,
    input  logic             rst_vga,
    input  logic             pix_en_vga,
    output logic             h_out_vga,
    output logic             v_out_vga,
    output logic             video_on,
    output logic [CNT_W-1:0] horizontal_x,
    output logic [CNT_W-1:0] vertical_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0]      rgb_vga
`endif
);

    localparam int H_TOTAL = H_VIZ + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_VIZ + V_FP + V_PULSE + V_BP;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIZ_C = CNT_W'(H_VIZ);
    localparam logic [CNT_W-1:0] V_VIZ_C = CNT_W'(V_VIZ);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIZ + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIZ + H_FP + H_PULSE);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIZ + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIZ + V_FP + V_PULSE);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic h_wrap;
    logic v_wrap;
    logic viz;
    logic h_sync;
    logic v_sync;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign viz    = (h_cnt < H_VIZ_C) && (v_cnt < V_VIZ_C);
    assign h_sync = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign v_sync = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // Compare-and-clear keeps both counters inside [0, TOTAL-1].
    always_ff @(posedge clk_vga or posedge rst_vga) begin
        if (rst_vga) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en_vga) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_vga or posedge rst_vga) begin
        if (rst_vga) begin
            h_out_vga    <= ~HS_ACT;
            v_out_vga    <= ~VS_ACT;
            video_on     <= 1'b0;
            horizontal_x <= '0;
            vertical_y   <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (pix_en_vga) begin
            h_out_vga    <= h_sync ? HS_ACT : ~HS_ACT;
            v_out_vga    <= v_sync ? VS_ACT : ~VS_ACT;
            video_on     <= viz;
            horizontal_x <= viz ? h_cnt : '0;
            vertical_y   <= viz ? v_cnt : '0;
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Narrow visible widths would give a zero bar width; clamp to 1 pixel.
    localparam int               BAR_W   = (H_VIZ / 8 > 0) ? H_VIZ / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

    logic [CNT_W-1:0] bar_idx;
    logic [11:0]      bar_rgb;

    assign bar_idx = h_cnt / BAR_W_C;

    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx[2:0])
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
        // Leftover pixels when H_VIZ is not a multiple of 8 fall in the black bar.
        if (bar_idx > CNT_W'(7)) begin
            bar_rgb = 12'h000;
        end
    end

    always_ff @(posedge clk_vga or posedge rst_vga) begin
        if (rst_vga) begin
            rgb_vga <= 12'h000;
        end else if (pix_en_vga) begin
            rgb_vga <= viz ? bar_rgb : 12'h000;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // default-parameter instance
    logic        d_hs, d_vs, d_von, d_ls, d_fs;
    logic [10:0] d_x, d_y;
    // small active-high instance: 8x4 visible, H 1/2/1, V 1/1/1, CNT_W=4
    logic        s_hs, s_vs, s_von, s_ls, s_fs;
    logic [3:0]  s_x, s_y;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] d_rgb, s_rgb;
`endif

    vga_timing_gen dut_d (
        .clk_vga(clk), .rst_vga(rst), .pix_en_vga(pix_en),
        .h_out_vga(d_hs), .v_out_vga(d_vs), .video_on(d_von),
        .horizontal_x(d_x), .vertical_y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb_vga(d_rgb)
`endif
    );

    vga_timing_gen #(
        .H_VIZ(8), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_VIZ(4), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CNT_W(4)
    ) dut_s (
        .clk_vga(clk), .rst_vga(rst), .pix_en_vga(pix_en),
        .h_out_vga(s_hs), .v_out_vga(s_vs), .video_on(s_von),
        .horizontal_x(s_x), .vertical_y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb_vga(s_rgb)
`endif
    );

    // Enabled ticks seen since reset released.
    longint k_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) k_cnt <= 0;
        else if (pix_en) k_cnt <= k_cnt + 1;
    end

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
    } vga_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bar_color(input int x, input int hv);
        int w;
        int b;
        w = (hv / 8 > 0) ? hv / 8 : 1;
        b = x / w;
        case (b)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Output after k enabled ticks: the raster position of tick k-1, taken
    // modulo the frame size, decoded straight from the timing rules.
    function automatic vga_t model(input int hv, hfp, hpw, hbp, vv, vfp, vpw, vbp,
                                   input int hpol, vpol, input longint k,
                                   output logic [11:0] rgb);
        vga_t   r;
        int     ht, vt, h, v;
        longint p;
        ht = hv + hfp + hpw + hbp;
        vt = vv + vfp + vpw + vbp;
        r.hs = ~hpol[0]; r.vs = ~vpol[0]; r.von = 1'b0;
        r.x = '0; r.y = '0; r.ls = 1'b0; r.fs = 1'b0;
        rgb = 12'h000;
        if (k > 0) begin
            p = (k - 1) % longint'(ht * vt);
            h = int'(p % longint'(ht));
            v = int'(p / longint'(ht));
            r.von = (h < hv) && (v < vv);
            if (r.von) begin
                r.x = 11'(h);
                r.y = 11'(v);
                rgb = bar_color(h, hv);
            end
            if (h >= hv + hfp && h < hv + hfp + hpw) r.hs = hpol[0];
            if (v >= vv + vfp && v < vv + vfp + vpw) r.vs = vpol[0];
            r.ls = (h == 0);
            r.fs = (h == 0) && (v == 0);
        end
        return r;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        vga_t        ed, es, ad, as_;
        logic [11:0] erd, ers;
        longint      k;
        k   = rst ? 0 : k_cnt;
        ed  = model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, k, erd);
        es  = model(8, 1, 2, 1, 4, 1, 1, 1, 1, 1, k, ers);
        ad  = {d_hs, d_vs, d_von, d_x, d_y, d_ls, d_fs};
        as_ = {s_hs, s_vs, s_von, 7'd0, s_x, 7'd0, s_y, s_ls, s_fs};
        check("dflt_cycle", 32'(ad), 32'(ed));
        check("small_cycle", 32'(as_), 32'(es));
`ifdef VGA_TEST_PATTERN_EN
        check("dflt_rgb_cycle", 32'(d_rgb), 32'(erd));
        check("small_rgb_cycle", 32'(s_rgb), 32'(ers));
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_first, hs_last, hs_low, von_cnt, ls_a, ls_b;
        int sfs_a, sfs_b, s_vs_cnt, s_hs_cnt, s_ymax;
        int rise1, rise2, ls_w;
        logic ls_prev;
        hs_first = 0; hs_last = 0; hs_low = 0; von_cnt = 0; ls_a = 0; ls_b = 0;
        sfs_a = 0; sfs_b = 0; s_vs_cnt = 0; s_hs_cnt = 0; s_ymax = 0;

        // reset held
        repeat (3) @(negedge clk);
        check("rst_d_hs", 32'(d_hs), 32'd1);
        check("rst_d_vs", 32'(d_vs), 32'd1);
        check("rst_d_von", 32'(d_von), 32'd0);
        check("rst_d_fs_ls", 32'({d_fs, d_ls}), 32'd0);
        check("rst_s_sync", 32'({s_hs, s_vs}), 32'd0);
        #1 rst = 1'b0;

        // two default lines, many small frames
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("first_fs", 32'(d_fs), 32'd1);
                check("first_ls", 32'(d_ls), 32'd1);
                check("first_von", 32'(d_von), 32'd1);
                check("first_xy", 32'({d_x, d_y}), 32'd0);
            end
            if (i <= 800) begin
                if (!d_hs) begin
                    if (hs_first == 0) hs_first = i;
                    hs_last = i;
                    hs_low++;
                end
                if (d_von) von_cnt++;
            end
            if (d_ls) begin
                if (ls_a == 0) ls_a = i;
                else if (ls_b == 0) ls_b = i;
            end
            if (s_fs) begin
                if (sfs_a == 0) sfs_a = i;
                else if (sfs_b == 0) sfs_b = i;
            end
            if (i <= 84 && s_vs) s_vs_cnt++;
            if (i <= 12) begin
                if (s_hs) s_hs_cnt++;
                check("s_x_seq", 32'(s_x), (i <= 8) ? 32'(i - 1) : 32'd0);
            end
            if (int'(s_y) > s_ymax) s_ymax = int'(s_y);
`ifdef VGA_TEST_PATTERN_EN
            if (i == 81) check("rgb_x80", 32'(d_rgb), 32'h0FF0);
            if (i == 700) check("rgb_blank", 32'(d_rgb), 32'h0000);
`endif
        end
        check("hs_first_tick", 32'(hs_first), 32'd657);
        check("hs_last_tick", 32'(hs_last), 32'd752);
        check("hs_low_len", 32'(hs_low), 32'd96);
        check("von_per_line", 32'(von_cnt), 32'd640);
        check("line_period", 32'(ls_b - ls_a), 32'd800);
        check("small_frame_period", 32'(sfs_b - sfs_a), 32'd84);
        check("small_vs_high", 32'(s_vs_cnt), 32'd12);
        check("small_hs_high", 32'(s_hs_cnt), 32'd2);
        check("small_y_max", 32'(s_ymax), 32'd3);

        // pixel enable on every 2nd clock
        rise1 = -1; rise2 = -1; ls_w = 0; ls_prev = d_ls;
        for (int c = 0; c < 4000; c++) begin
            #1 pix_en = (c % 2) == 0;
            @(negedge clk);
            if (d_ls && !ls_prev) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (d_ls && rise1 >= 0 && rise2 < 0) ls_w++;
            ls_prev = d_ls;
        end
        check("stall_line_period", 32'(rise2 - rise1), 32'd1600);
        check("stall_pulse_width", 32'(ls_w), 32'd2);

        // async reset mid-line at h_cnt = 300
        #1 pix_en = 1'b1;
        for (int j = 0; j < 900 && (k_cnt % 800) != 300; j++) @(negedge clk);
        check("reach_h300", 32'(k_cnt % 800), 32'd300);
        #1 rst = 1'b1;
        #1;
        check("async_d_von", 32'(d_von), 32'd0);
        check("async_d_x", 32'(d_x), 32'd0);
        check("async_d_sync", 32'({d_hs, d_vs}), 32'h3);
        check("async_s_sync", 32'({s_hs, s_vs}), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("restart_fs", 32'(d_fs), 32'd1);
        check("restart_xy", 32'({d_von, d_x, d_y}), 32'h400000);
        repeat (300) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
